noise_filter_seq: RTL and testbench
===================================

# noise_filter_seq

Sequencing controller for the salt-and-pepper mean filter. It accepts one 3x3 pixel window per handshake and time-multiplexes a single `Detector` cell (NoD=1 iff pixel is 0x00 or 0xFF) over the centre and its eight neighbours. A clean centre passes through unchanged; a noisy centre is replaced by the truncated mean of the clean neighbours. When every neighbour is noisy, the block falls back to the last output pixel (feedback path). It sits between the window builder (upstream) and the output pixel stream (downstream).

## Interface
- `INIT_PREV`, default 8'd128: reset value of the feedback register.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `win_valid` input 1: window is offered.
- `win_ready` output 1: block can accept a window; high only in IDLE.
- `win_data` input 72: pixel k in bits [8k+7:8k], k=0..8 in raster order; centre is k=4.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `out_pix` output 8: filtered centre pixel.
- `out_noisy` output 1: centre pixel was detected as noisy.
- `busy` output 1: state is not IDLE.

## Operation
- Exactly one `Detector` instance. Its input is muxed from the latched window by the scan index.
- States and transitions:
  - IDLE: on `win_valid && win_ready`, latch `win_data` and go to CHK_C.
  - CHK_C: test the centre.
    - Clean: `out_pix` = centre, `out_noisy` = 0, go to OUT.
    - Noisy: clear sum and count, go to SCAN.
  - SCAN: 8 cycles, neighbours k = 0,1,2,3,5,6,7,8 in that order.
    - If a neighbour is clean: sum += pixel (11-bit, max 2040) and cnt += 1 (4-bit, max 8).
  - After SCAN:
    - cnt = 0: `out_pix` = feedback result (see Configuration), go to OUT.
    - cnt > 0: go to DIV.
  - DIV: 11-cycle restoring division, sum / cnt.
    - Quotient is truncated; it always fits in 8 bits.
    - `out_pix` = quotient, `out_noisy` = 1, go to OUT.
  - OUT: hold `out_valid` = 1. On `out_ready`:
    - Update `prev` <= `out_pix`.
    - Drop `out_valid`.
    - Go to IDLE.
- `prev` is updated on every output handshake, whether the pixel was clean or filtered.
- `win_valid` is ignored outside IDLE; the latched window is unaffected by `win_data` changes.
- `out_pix` and `out_noisy` stay stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `win_ready` 1, `out_valid` 0, `out_pix` 0, `out_noisy` 0, `busy` 0, `prev` = `INIT_PREV`, sum/cnt 0.
- `win_ready` = (state == IDLE), combinational. `out_valid` is registered.
- Latency from the input handshake at cycle T to the first `out_valid` cycle:
  - Clean centre: T+2.
  - Noisy centre, cnt = 0: T+10.
  - Noisy centre, cnt > 0: T+21.
- Back-to-back throughput: the next window is accepted earliest one cycle after the output handshake.
- Reset asserted at any state: outputs go to their reset values immediately (asynchronous). The in-flight window and partial sum are discarded, and `prev` returns to `INIT_PREV`.
- `out_ready` high in the same cycle `out_valid` rises: the handshake completes in that cycle.

## Configuration
- `NF_SEQ_FEEDBACK_EN` defined: when cnt = 0, output `prev` (last output pixel, or `INIT_PREV` after reset).
- `NF_SEQ_FEEDBACK_EN` undefined: `prev` and `INIT_PREV` are unused and removed. When cnt = 0, output the noisy centre pixel unchanged. `out_noisy` is still 1.

## Test plan
- Window with centre 0x5A, `out_ready` = 1 -> `out_pix` = 0x5A, `out_noisy` = 0, `out_valid` at T+2 for 1 cycle.
- Centre 0x00, neighbours 10, 20, …, 80 -> sum 360, cnt 8, `out_pix` = 45 (0x2D), `out_noisy` = 1, at T+21.
- Centre 0xFF, neighbours 0x00, 100, 0xFF, 101, 102, 0x00, 104, 0xFF -> sum 407, cnt 4, `out_pix` = 101, at T+21.
- After reset, all nine pixels 0xFF:
  - With the macro: `out_pix` = 128 at T+10.
  - Then previous case, then all-noisy again: `out_pix` = 101.
  - Without the macro: `out_pix` = 0xFF.
- Hold `out_ready` = 0 for 5 cycles during OUT while toggling `win_valid`/`win_data` -> `out_pix` stable, `win_ready` = 0, no window accepted, result intact on release.
- Assert `rst_n` = 0 during SCAN cycle 4 -> `out_valid` = 0, `busy` = 0, `win_ready` = 1 immediately. The next all-noisy window outputs `INIT_PREV` (with the macro).

Source files
------------

// File: rtl/noise_filter_seq.sv
// rtl/noise_filter_seq.sv - sequenced salt-and-pepper mean filter with one shared detector (optional NF_SEQ_FEEDBACK_EN)

// Flags a pixel as impulse noise when it sits at either rail.
module nf_detector (
    input  logic [7:0] pix_i,
    output logic       noisy_o
);
    assign noisy_o = (pix_i == 8'h00) || (pix_i == 8'hFF);
endmodule

module noise_filter_seq
`ifdef NF_SEQ_FEEDBACK_EN
#(
    parameter logic [7:0] INIT_PREV = 8'd128
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        win_valid,
    output logic        win_ready,
    input  logic [71:0] win_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_pix,
    output logic        out_noisy,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHK_C = 3'd1,
        S_SCAN  = 3'd2,
        S_DIV   = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t      state_q;
    logic [71:0] win_q;
    logic [10:0] sum_q;      // neighbour sum, then reused as dividend/quotient shift register
    logic [3:0]  cnt_q;      // clean-neighbour count, also the divisor
    logic [4:0]  rem_q;      // partial remainder of the restoring divider
    logic [2:0]  scan_q;     // neighbour scan position 0..7
    logic [3:0]  div_q;      // divider step 0..10
    logic [7:0]  out_pix_q;
    logic        out_noisy_q;
    logic        out_valid_q;
`ifdef NF_SEQ_FEEDBACK_EN
    logic [7:0]  prev_q;
`endif

    logic [3:0]  nb_idx;
    logic [3:0]  det_idx;
    logic [7:0]  det_pix;
    logic        det_noisy;
    logic        det_clean;
    logic [10:0] sum_d;
    logic [3:0]  cnt_d;
    logic [4:0]  rem_sh;
    logic        quo_bit;
    logic [4:0]  rem_d;
    logic [10:0] quo_d;
    logic [7:0]  fallback_pix;

    assign win_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_noisy = out_noisy_q;

    // Route the centre during CHK_C and the current neighbour (skipping k=4) during SCAN.
    always_comb begin
        nb_idx  = (scan_q < 3'd4) ? {1'b0, scan_q} : ({1'b0, scan_q} + 4'd1);
        det_idx = (state_q == S_SCAN) ? nb_idx : 4'd4;
        det_pix = win_q[{det_idx, 3'b000} +: 8];
    end

    nf_detector u_detector (
        .pix_i   (det_pix),
        .noisy_o (det_noisy)
    );

    assign det_clean = ~det_noisy;

    // Accumulator next values and one restoring-division step.
    always_comb begin
        sum_d   = sum_q + (det_clean ? {3'b000, det_pix} : 11'd0);
        cnt_d   = cnt_q + {3'b000, det_clean};
        rem_sh  = {rem_q[3:0], sum_q[10]};
        quo_bit = (rem_sh >= {1'b0, cnt_q});
        rem_d   = quo_bit ? (rem_sh - {1'b0, cnt_q}) : rem_sh;
        quo_d   = {sum_q[9:0], quo_bit};
    end

    // Value used when no neighbour is clean: last output pixel, or the noisy centre itself.
    always_comb begin
`ifdef NF_SEQ_FEEDBACK_EN
        fallback_pix = prev_q;
`else
        fallback_pix = win_q[39:32];
`endif
    end

    // Main sequencer: window latch, centre test, neighbour scan, divide, output hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            scan_q      <= '0;
            div_q       <= '0;
            out_pix_q   <= '0;
            out_noisy_q <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef NF_SEQ_FEEDBACK_EN
            prev_q      <= INIT_PREV;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_valid) begin
                        win_q   <= win_data;
                        state_q <= S_CHK_C;
                    end
                end
                S_CHK_C: begin
                    if (det_clean) begin
                        out_pix_q   <= det_pix;
                        out_noisy_q <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        scan_q  <= '0;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    sum_q  <= sum_d;
                    cnt_q  <= cnt_d;
                    scan_q <= scan_q + 3'd1;
                    if (scan_q == 3'd7) begin
                        if (cnt_d == 4'd0) begin
                            out_pix_q   <= fallback_pix;
                            out_noisy_q <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= S_OUT;
                        end else begin
                            rem_q   <= '0;
                            div_q   <= '0;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    sum_q <= quo_d;
                    rem_q <= rem_d;
                    div_q <= div_q + 4'd1;
                    if (div_q == 4'd10) begin
                        // Mean of 8-bit values never exceeds 8 bits, so the upper quotient bits are zero.
                        out_pix_q   <= quo_d[7:0];
                        out_noisy_q <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef NF_SEQ_FEEDBACK_EN
                        prev_q      <= out_pix_q;
`endif
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noise_filter_seq.sv
// tb/tb_noise_filter_seq.sv - table-driven scoreboard bench for noise_filter_seq

module tb_noise_filter_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pix;
    logic        out_noisy;
    logic        busy;

    int checks   = 0;
    int failures = 0;

`ifdef NF_SEQ_FEEDBACK_EN
    localparam bit FB = 1'b1;
`else
    localparam bit FB = 1'b0;
`endif

    typedef struct {
        logic [71:0] win;
        logic [7:0]  pix;
        logic        noisy;
        int          lat;
        bit          fb;     // all neighbours noisy: expected pixel comes from the feedback model
    } vec_t;

    typedef struct {
        logic [7:0] pix;
        logic       noisy;
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    vec_t       vt[11];
    logic [7:0] prev_m;

    noise_filter_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_noisy (out_noisy),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                                       input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                                       input logic [7:0] p6, input logic [7:0] p7, input logic [7:0] p8);
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    function automatic vec_t mv(input logic [71:0] w, input logic [7:0] p, input logic n, input int l, input bit f);
        vec_t v;
        v.win = w; v.pix = p; v.noisy = n; v.lat = l; v.fb = f;
        return v;
    endfunction

    // Offer one window, wait for the result, hold out_ready low for 'hold' cycles, then release.
    task automatic send(input vec_t v, input int hold, input string tag);
        exp_t        e;
        exp_t        got_e;
        int          n;
        logic [71:0] junk;
        e.pix   = v.fb ? (FB ? prev_m : v.win[39:32]) : v.pix;
        e.noisy = v.noisy;
        e.lat   = v.lat;
        out_ready = (hold == 0);
        chk({tag, ".win_ready_idle"}, int'(win_ready), 1);
        win_valid = 1'b1;
        win_data  = v.win;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        win_data  = {$urandom, $urandom, $urandom};
        chk({tag, ".busy_after_accept"}, int'(busy), 1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout: out_valid never rose within %0d cycles", tag, n);
            void'(sb_q.pop_front());
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
            prev_m = 8'd128;
            return;
        end
        got_e = sb_q.pop_front();
        chk({tag, ".pix"}, int'(out_pix), int'(got_e.pix));
        chk({tag, ".noisy"}, int'(out_noisy), int'(got_e.noisy));
        chk({tag, ".latency"}, n + 1, got_e.lat);
        for (int i = 0; i < hold; i++) begin
            junk      = {$urandom, $urandom, $urandom};
            win_valid = ~win_valid;
            win_data  = junk;
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, int'(out_valid), 1);
            chk({tag, ".hold_pix"}, int'(out_pix), int'(got_e.pix));
            chk({tag, ".hold_win_ready"}, int'(win_ready), 0);
        end
        win_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        prev_m = got_e.pix;
        chk({tag, ".valid_drop"}, int'(out_valid), 0);
        chk({tag, ".idle_after"}, int'(busy), 0);
    endtask

    initial begin
        vt[0]  = mv(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'd0, 1'b1, 10, 1'b1);
        vt[1]  = mv(mk(8'd1, 8'd2, 8'd3, 8'd4, 8'h5A, 8'd6, 8'd7, 8'd8, 8'd9), 8'h5A, 1'b0, 2, 1'b0);
        vt[2]  = mv(mk(8'd10, 8'd20, 8'd30, 8'd40, 8'h00, 8'd50, 8'd60, 8'd70, 8'd80), 8'd45, 1'b1, 21, 1'b0);
        vt[3]  = mv(mk(8'h00, 8'd100, 8'hFF, 8'd101, 8'hFF, 8'd102, 8'h00, 8'd104, 8'hFF), 8'd101, 1'b1, 21, 1'b0);
        vt[4]  = mv(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'd0, 1'b1, 10, 1'b1);
        vt[5]  = mv(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8'd0, 1'b1, 10, 1'b1);
        vt[6]  = mv(mk(8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'd254), 8'd254, 1'b1, 21, 1'b0);
        vt[7]  = mv(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'd1, 1'b0, 2, 1'b0);
        vt[8]  = mv(mk(8'd254, 8'd254, 8'd254, 8'd254, 8'hFF, 8'd254, 8'd254, 8'd254, 8'd254), 8'd254, 1'b1, 21, 1'b0);
        vt[9]  = mv(mk(8'd1, 8'd2, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'd1, 1'b1, 21, 1'b0);
        vt[10] = mv(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 8'd0, 1'b1, 10, 1'b1);

        rst_n     = 1'b0;
        win_valid = 1'b0;
        win_data  = '0;
        out_ready = 1'b1;
        prev_m    = 8'd128;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.win_ready", int'(win_ready), 1);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.out_pix", int'(out_pix), 0);
        chk("reset.out_noisy", int'(out_noisy), 0);
        chk("reset.busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            send(vt[i], 0, $sformatf("vec%0d", i));
        end

        // Backpressure during OUT with noise on the input side.
        send(vt[3], 5, "hold_filtered");
        send(vt[1], 5, "hold_clean");

        // Reset in the middle of a neighbour scan.
        win_valid = 1'b1;
        win_data  = vt[2].win;
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midscan.busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midscan.out_valid", int'(out_valid), 0);
        chk("midscan.busy", int'(busy), 0);
        chk("midscan.win_ready", int'(win_ready), 1);
        prev_m = 8'd128;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(vt[4], 0, "after_reset_allnoisy");
        send(vt[2], 0, "after_reset_mean");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
